half_class_enumerator: RTL and testbench

//  Stream generator, inverse of the half_precision classifier: takes a class

---
 rtl/half_fp_pkg.sv | 41 ++++
 rtl/half_class_range.sv | 58 +++++
 rtl/half_class_enumerator.sv | 141 ++++++++++++++
 tb/tb_half_class_enumerator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/half_fp_pkg.sv
// half_fp_pkg
//   Shared binary16 field widths, class codes and per-class encoding totals.
//   Used by the class enumerator and by classifier-side logic and benches.
package half_fp_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int N     = 1 + EXP_W + MAN_W;

  localparam logic [2:0] CLS_SNAN      = 3'd0;
  localparam logic [2:0] CLS_QNAN      = 3'd1;
  localparam logic [2:0] CLS_INF       = 3'd2;
  localparam logic [2:0] CLS_ZERO      = 3'd3;
  localparam logic [2:0] CLS_SUBNORMAL = 3'd4;
  localparam logic [2:0] CLS_NORMAL    = 3'd5;

  localparam int TOTAL_SNAN      = 1022;
  localparam int TOTAL_QNAN      = 1024;
  localparam int TOTAL_INF       = 2;
  localparam int TOTAL_ZERO      = 2;
  localparam int TOTAL_SUBNORMAL = 2046;
  localparam int TOTAL_NORMAL    = 61440;

  // Field constants: all-ones exponent, largest finite exponent, quiet bit.
  localparam logic [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_MAX  = '1;
  localparam logic [EXP_W-1:0] EXP_FMAX = {{(EXP_W-1){1'b1}}, 1'b0};

  localparam logic [MAN_W-1:0] MAN_ZERO  = '0;
  localparam logic [MAN_W-1:0] MAN_ONE   = MAN_W'(1);
  localparam logic [MAN_W-1:0] MAN_MAX   = '1;
  localparam logic [MAN_W-1:0] MAN_QUIET = {1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [MAN_W-1:0] MAN_SMAX  = {1'b0, {(MAN_W-1){1'b1}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } enum_state_t;

endpackage

// File: rtl/half_class_range.sv
// half_class_range
//   Combinational map from a class code to the exponent and mantissa ranges
//   that enumerate that class (same ranges for both signs).
// Ports
//   class_sel  in   3      class code
//   exp_lo/hi  out  EXP_W  first/last exponent value
//   man_lo/hi  out  MAN_W  first/last mantissa value within each exponent
//   valid      out  1      class code is one of the six defined classes
module half_class_range
  import half_fp_pkg::*;
(
  input  logic [2:0]       class_sel,
  output logic [EXP_W-1:0] exp_lo,
  output logic [EXP_W-1:0] exp_hi,
  output logic [MAN_W-1:0] man_lo,
  output logic [MAN_W-1:0] man_hi,
  output logic             valid
);

  always_comb begin
    exp_lo = EXP_ZERO;
    exp_hi = EXP_ZERO;
    man_lo = MAN_ZERO;
    man_hi = MAN_ZERO;
    valid  = 1'b1;
    case (class_sel)
      CLS_SNAN: begin
        exp_lo = EXP_MAX;
        exp_hi = EXP_MAX;
        man_lo = MAN_ONE;
        man_hi = MAN_SMAX;
      end
      CLS_QNAN: begin
        exp_lo = EXP_MAX;
        exp_hi = EXP_MAX;
        man_lo = MAN_QUIET;
        man_hi = MAN_MAX;
      end
      CLS_INF: begin
        exp_lo = EXP_MAX;
        exp_hi = EXP_MAX;
      end
      CLS_ZERO: begin
      end
      CLS_SUBNORMAL: begin
        man_lo = MAN_ONE;
        man_hi = MAN_MAX;
      end
      CLS_NORMAL: begin
        exp_lo = EXP_ONE;
        exp_hi = EXP_FMAX;
        man_hi = MAN_MAX;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/half_class_enumerator.sv
// half_class_enumerator
//   Emits every binary16 encoding of a selected class, one word per
//   valid/ready handshake: sign 0 then 1, exponent ascending, mantissa
//   ascending (innermost).
// Ports
//   clk, rst           clock; synchronous active-high reset
//   start_valid/ready  start request for class_sel (ready only in IDLE)
//   class_sel          class code 0..5; 6/7 rejected with an err pulse
//   abort              ends the current enumeration without done
//   out_valid/ready    output stream handshake
//   out_f, out_last    encoding and final-word flag
//   count              beats accepted since the last start
//   done               1-cycle pulse after the final beat is accepted
//   err                1-cycle pulse after a start with an invalid class
//
//   state | meaning
//   IDLE  | waiting for start; start_ready high
//   RUN   | presenting {sign,exp,man}; advance on each handshake
module half_class_enumerator
  import half_fp_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [2:0]   class_sel,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_f,
  output logic         out_last,
  output logic [N-1:0] count,
  output logic         done,
  output logic         err
);

  enum_state_t state_q, state_d;

  logic [EXP_W-1:0] rng_exp_lo, rng_exp_hi;
  logic [MAN_W-1:0] rng_man_lo, rng_man_hi;
  logic             rng_valid;

  // Range bounds are captured at start so class_sel may change during RUN.
  logic [EXP_W-1:0] exp_lo_q, exp_hi_q, exp_q;
  logic [MAN_W-1:0] man_lo_q, man_hi_q, man_q;
  logic             sign_q;

  logic start_ok, start_bad, hs, at_last;

  half_class_range u_range (
    .class_sel (class_sel),
    .exp_lo    (rng_exp_lo),
    .exp_hi    (rng_exp_hi),
    .man_lo    (rng_man_lo),
    .man_hi    (rng_man_hi),
    .valid     (rng_valid)
  );

  assign at_last = sign_q & (exp_q == exp_hi_q) & (man_q == man_hi_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Outputs depend only on registered state, so out_ready never reaches
  // out_valid combinationally.
  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    start_ok    = 1'b0;
    start_bad   = 1'b0;
    hs          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_ready = 1'b1;
        start_ok    = start_valid & rng_valid;
        start_bad   = start_valid & ~rng_valid;
        if (start_ok) state_d = ST_RUN;
      end
      ST_RUN: begin
        out_valid = 1'b1;
        out_last  = at_last;
        // abort wins over a same-cycle handshake
        hs        = out_ready & ~abort;
        if (abort || (hs && at_last)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q   <= 1'b0;
      exp_q    <= EXP_ZERO;
      man_q    <= MAN_ZERO;
      exp_lo_q <= EXP_ZERO;
      exp_hi_q <= EXP_ZERO;
      man_lo_q <= MAN_ZERO;
      man_hi_q <= MAN_ZERO;
      count    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (start_ok) begin
        sign_q   <= 1'b0;
        exp_q    <= rng_exp_lo;
        man_q    <= rng_man_lo;
        exp_lo_q <= rng_exp_lo;
        exp_hi_q <= rng_exp_hi;
        man_lo_q <= rng_man_lo;
        man_hi_q <= rng_man_hi;
        count    <= '0;
      end else if (start_bad) begin
        err <= 1'b1;
      end
      if (hs) begin
        count <= count + N'(1);
        if (at_last) done <= 1'b1;
        if (man_q == man_hi_q) begin
          man_q <= man_lo_q;
          if (exp_q == exp_hi_q) begin
            exp_q  <= exp_lo_q;
            sign_q <= ~sign_q;
          end else begin
            exp_q <= exp_q + EXP_W'(1);
          end
        end else begin
          man_q <= man_q + MAN_W'(1);
        end
      end
    end
  end

  assign out_f = {sign_q, exp_q, man_q};

endmodule

// File: tb/tb_half_class_enumerator.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor pops
// and compares on every accepted beat.
module tb_half_class_enumerator;
  import half_fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start_valid, abort, out_ready;
  logic [2:0]  class_sel;
  logic        start_ready, out_valid, out_last, done, err;
  logic [15:0] out_f, count;

  typedef struct {
    logic [15:0] f;
    logic        last;
    logic [2:0]  cls;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  int checks = 0, errors = 0, beats = 0, done_cnt = 0, err_cnt = 0;
  logic ready_rand = 1'b0;
  logic stall_prev = 1'b0;
  logic [15:0] held_f = '0;

  half_class_enumerator dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .class_sel(class_sel), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_f(out_f), .out_last(out_last),
    .count(count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] classify(input logic [15:0] f);
    if (f[14:10] == 5'h1f) begin
      if (f[9:0] == 10'd0) return CLS_INF;
      return f[9] ? CLS_QNAN : CLS_SNAN;
    end
    if (f[14:10] == 5'd0) return (f[9:0] == 10'd0) ? CLS_ZERO : CLS_SUBNORMAL;
    return CLS_NORMAL;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev && out_valid) chk("stable_f", 32'(out_f), 32'(held_f));
      if (out_valid && out_ready && !abort) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", 32'(out_f), 32'hffffffff);
        end else begin
          e_mon = sb.pop_front();
          chk("word", 32'(out_f), 32'(e_mon.f));
          chk("last", 32'(out_last), 32'(e_mon.last));
          chk("class", 32'(classify(out_f)), 32'(e_mon.cls));
        end
        beats++;
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      stall_prev = out_valid && !out_ready && !abort;
      held_f = out_f;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_rand) out_ready = ($urandom_range(0, 7) != 0);
    end
  end

  task automatic push_word(input logic [15:0] f, input logic last, input logic [2:0] cls);
    exp_t e;
    e.f = f; e.last = last; e.cls = cls;
    sb.push_back(e);
  endtask

  task automatic push_class(input logic [2:0] cls);
    int elo, ehi, mlo, mhi;
    case (cls)
      CLS_SNAN:      begin elo = 31; ehi = 31; mlo = 1;   mhi = 511;  end
      CLS_QNAN:      begin elo = 31; ehi = 31; mlo = 512; mhi = 1023; end
      CLS_INF:       begin elo = 31; ehi = 31; mlo = 0;   mhi = 0;    end
      CLS_ZERO:      begin elo = 0;  ehi = 0;  mlo = 0;   mhi = 0;    end
      CLS_SUBNORMAL: begin elo = 0;  ehi = 0;  mlo = 1;   mhi = 1023; end
      default:       begin elo = 1;  ehi = 30; mlo = 0;   mhi = 1023; end
    endcase
    for (int s = 0; s < 2; s++)
      for (int e = elo; e <= ehi; e++)
        for (int m = mlo; m <= mhi; m++)
          push_word({s[0], e[4:0], m[9:0]}, (s == 1 && e == ehi && m == mhi), cls);
  endtask

  task automatic do_start(input logic [2:0] cls);
    @(posedge clk); #1;
    class_sel = cls;
    start_valid = 1'b1;
    beats = 0;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int total);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("count_total", 32'(count), 32'(total));
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_ready", 32'(start_ready), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beats < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beats_reached", 32'(beats), 32'(target));
  endtask

  initial begin
    int d0, e0;
    rst = 1'b1; start_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; class_sel = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(start_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_f", 32'(out_f), 32'd0);
    chk("rst_flags", 32'({out_last, done, err}), 32'd0);
    rst = 1'b0;

    // INF
    out_ready = 1'b1;
    push_word(16'h7C00, 1'b0, CLS_INF);
    push_word(16'hFC00, 1'b1, CLS_INF);
    do_start(CLS_INF);
    chk("latency_inf", 32'(out_valid), 32'd1);
    wait_done(20, 2);

    // SNAN
    push_class(CLS_SNAN);
    do_start(CLS_SNAN);
    chk("latency_snan", 32'(out_valid), 32'd1);
    wait_done(1200, 1022);

    // invalid class
    e0 = err_cnt;
    do_start(3'd6);
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_valid", 32'(out_valid), 32'd0);
    chk("err_ready", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    chk("err_clear", 32'(err), 32'd0);
    chk("err_once", 32'(err_cnt - e0), 32'd1);
    chk("err_no_run", 32'(out_valid), 32'd0);

    // SUBNORMAL interrupted by reset
    d0 = done_cnt;
    push_class(CLS_SUBNORMAL);
    do_start(CLS_SUBNORMAL);
    wait_beats(100, 300);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_ready", 32'(start_ready), 32'd1);
    rst = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_nodone", 32'(done_cnt - d0), 32'd0);

    // ZERO
    push_word(16'h0000, 1'b0, CLS_ZERO);
    push_word(16'h8000, 1'b1, CLS_ZERO);
    do_start(CLS_ZERO);
    wait_done(20, 2);

    // QNAN, start held through RUN, abort after 10 beats
    d0 = done_cnt;
    push_class(CLS_QNAN);
    @(posedge clk); #1;
    class_sel = CLS_QNAN;
    start_valid = 1'b1;
    beats = 0;
    @(posedge clk); #1;
    chk("latency_qnan", 32'(out_valid), 32'd1);
    wait_beats(5, 40);
    chk("run_not_ready", 32'(start_ready), 32'd0);
    wait_beats(10, 40);
    abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_count", 32'(count), 32'd10);
    abort = 1'b0;
    start_valid = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_nodone", 32'(done_cnt - d0), 32'd0);
    chk("abort_count_hold", 32'(count), 32'd10);

    // NORMAL with random back-pressure
    push_class(CLS_NORMAL);
    ready_rand = 1'b1;
    do_start(CLS_NORMAL);
    chk("latency_normal", 32'(out_valid), 32'd1);
    wait_done(80000, 61440);
    ready_rand = 1'b0;
    out_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
